// File: rtl/anneal_sequencer.sv
// anneal_sequencer: per-iteration command sequencer for the replica array,
// issuing random/distance/Metropolis commands with periodic replica exchange.
package anneal_pkg;
    typedef enum logic [1:0] {THR = 2'd0, OR1 = 2'd1, TWO = 2'd2} opt_command_t;
    typedef enum logic [1:0] {NOP = 2'd0, SELF = 2'd1, FOLW = 2'd2} exchange_command_t;
endpackage

module anneal_sequencer
    import anneal_pkg::*;
#(
    parameter int DIST_WAIT  = 21,
    parameter int METRO_WAIT = 2,
    parameter int EXCH_WAIT  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       iter_num,
    input  logic [15:0]       exch_interval,
    input  logic [1:0]        op_mode,
    output logic              random_run,
    output logic              run_distance,
    output opt_command_t      opt_com,
    output logic              run_command,
    output exchange_command_t c_exchange,
    output exchange_command_t c_metropolis,
    output logic              busy,
    output logic              done,
    output logic [31:0]       iter_count
);
    typedef enum logic [3:0] {IDLE, RAND, DIST, DWAIT, METRO, MWAIT, EXCH, EFOLW, EWAIT, FIN} state_t;

    state_t            state, state_d;
    logic [15:0]       wcnt, wcnt_d, ecnt, ecnt_d, exi, exi_d, wlen;
    logic [31:0]       itn, itn_d, cnt_d;
    logic [1:0]        mode, mode_d;
    logic              hold, hold_d, last, waiting;
    logic              rr_d, rd_d, rc_d, busy_d, done_d;
    opt_command_t      op, oc_d;
    exchange_command_t cm_d;

    assign op      = mode == 2'd1 ? TWO : (mode == 2'd2 && iter_count[0]) ? TWO : OR1;
    assign wlen    = state == DWAIT ? 16'(DIST_WAIT) : state == MWAIT ? 16'(METRO_WAIT) : 16'(EXCH_WAIT);
    assign waiting = state == DWAIT || state == MWAIT || state == EWAIT;
    assign last    = wcnt + 16'd1 >= wlen;

    // Outputs are registered decodes of the current state, so each command
    // appears one cycle after its state is entered.
    always_comb begin
        state_d = state;
        wcnt_d  = (waiting && !last) ? wcnt + 16'd1 : 16'd0;
        ecnt_d  = ecnt;
        exi_d   = exi;
        itn_d   = itn;
        mode_d  = mode;
        hold_d  = hold;
        cnt_d   = iter_count;
        rr_d    = state == RAND;
        rd_d    = state == DIST;
        rc_d    = state == EXCH;
        cm_d    = state == METRO ? SELF : state == EFOLW ? FOLW : NOP;
        oc_d    = (state == RAND || state == DIST || state == DWAIT) ? op : THR;
        busy_d  = state != IDLE;
        done_d  = state == FIN && !hold;
        case (state)
            IDLE: if (start && !busy) begin
                itn_d  = iter_num;
                exi_d  = exch_interval;
                ecnt_d = exch_interval;
                mode_d = op_mode == 2'd3 ? 2'd0 : op_mode;
                if (iter_num != 32'd0) begin
                    state_d = RAND;
                    cnt_d   = 32'd0;
                end else begin
                    state_d = FIN;
                    hold_d  = 1'b1;
                end
            end
            RAND:  state_d = DIST;
            DIST:  state_d = DWAIT;
            DWAIT: state_d = last ? METRO : DWAIT;
            METRO: state_d = MWAIT;
            MWAIT: if (last) begin
                cnt_d  = iter_count + 32'd1;
                ecnt_d = ecnt - 16'd1;
                if (ecnt == 16'd1 && exi != 16'd0) begin
                    state_d = EXCH;
                    ecnt_d  = exi;
                end else begin
                    state_d = (iter_count + 32'd1 == itn) ? FIN : RAND;
                end
            end
            EXCH:  state_d = EFOLW;
            EFOLW: state_d = EWAIT;
            EWAIT: state_d = last ? ((iter_count == itn) ? FIN : RAND) : EWAIT;
            // a zero-iteration run lingers one extra cycle in FIN
            FIN: begin
                hold_d  = 1'b0;
                state_d = hold ? FIN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_d = IDLE;
            wcnt_d  = 16'd0;
            hold_d  = 1'b0;
            cnt_d   = iter_count;
            rr_d    = 1'b0;
            rd_d    = 1'b0;
            rc_d    = 1'b0;
            cm_d    = NOP;
            oc_d    = THR;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wcnt         <= 16'd0;
            ecnt         <= 16'd0;
            exi          <= 16'd0;
            itn          <= 32'd0;
            mode         <= 2'd0;
            hold         <= 1'b0;
            iter_count   <= 32'd0;
            random_run   <= 1'b0;
            run_distance <= 1'b0;
            run_command  <= 1'b0;
            opt_com      <= THR;
            c_exchange   <= NOP;
            c_metropolis <= NOP;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            wcnt         <= wcnt_d;
            ecnt         <= ecnt_d;
            exi          <= exi_d;
            itn          <= itn_d;
            mode         <= mode_d;
            hold         <= hold_d;
            iter_count   <= cnt_d;
            random_run   <= rr_d;
            run_distance <= rd_d;
            run_command  <= rc_d;
            opt_com      <= oc_d;
            c_exchange   <= NOP;
            c_metropolis <= cm_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end
endmodule
